uart_result_tx: RTL and testbench

- Serial transmitter for the classifier result: the outbound end of the 8N1 UART link whose receiver feeds image data into neural_network.
- On a one-cycle send pulse, latches the 4-bit argmax digit, converts it to ASCII and shifts it out LSB-first on tx_serial.
- Sits beside neural_network in the top level, clocked by the same divided clock. Its send input is driven from the network's done pulse.

---
 rtl/uart_result_tx.sv | 190 +++++++++++++++++++
 tb/tb_uart_result_tx.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/uart_result_tx.sv
// uart_result_tx: 8N1 UART transmitter for the classifier's argmax digit.
//
// When send is accepted, the 4-bit digit is latched as ASCII ('0'..'9', or '?'
// for 10..15) and shifted out LSB-first on tx_serial.
//
// Optional build macro: UART_RESULT_TX_CRLF_EN. When it is defined, every
// request sends three frames: the digit, then 0x0D, then 0x0A.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per UART bit (2..65535)
//   CNT_W         baud counter width; must hold CLKS_PER_BIT-1
//
// Ports:
//   clk        system clock (the divided clock in the top level)
//   resetn     asynchronous active-low reset
//   send       one-cycle transmit request; ignored while busy
//   digit      argmax result, sampled in the cycle send is accepted
//   tx_serial  UART line, idles high
//   busy       high from the cycle after acceptance until the frame(s) finish
//   tx_done    one-cycle pulse in the final stop-bit cycle
module uart_result_tx #(
  parameter int unsigned CLKS_PER_BIT = 10,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       send,
  input  logic [3:0] digit,
  output logic       tx_serial,
  output logic       busy,
  output logic       tx_done
);

  localparam int unsigned BIT_W  = 3;
  localparam int unsigned BYTE_W = 2;

  // Index of the last frame of a request: the digit alone, or digit + CR + LF.
`ifdef UART_RESULT_TX_CRLF_EN
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(2);
`else
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(0);
`endif

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    NEXT  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [7:0]          shreg_q, shreg_d;
  logic [BYTE_W-1:0]   byte_q, byte_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                cnt_last;
  logic                cnt_pre;
  logic                last_byte;

  // Digit to ASCII: 0..9 -> '0'..'9', anything else -> '?'.
  function automatic logic [7:0] encode(input logic [3:0] d);
    if (d < 4'd10) begin
      return 8'h30 + {4'h0, d};
    end
    return 8'h3F;
  endfunction

  assign cnt_last  = (cnt_q == CNT_LAST);
  assign cnt_pre   = (cnt_q == CNT_PRE);
  assign last_byte = (byte_q == LAST_BYTE);

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      byte_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      byte_q  <= byte_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; the line level is derived from the next state so that
  // tx_serial is a plain flop output and never glitches.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    byte_d  = byte_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (send) begin
          shreg_d = encode(digit);
          cnt_d   = '0;
          bit_d   = '0;
          byte_d  = '0;
          state_d = START;
        end
      end

      START: begin
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DATA: begin
        if (cnt_last) begin
          cnt_d   = '0;
          shreg_d = {1'b0, shreg_q[7:1]};
          if (bit_q == BIT_W'(7)) begin
            bit_d   = '0;
            state_d = STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      STOP: begin
        // Flag one cycle early so the registered pulse lands in the last stop cycle.
        if (cnt_pre && last_byte) begin
          done_d = 1'b1;
        end
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = last_byte ? IDLE : NEXT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      NEXT: begin
        // Only reachable in the CR/LF build: load CR after the digit, LF after CR.
        shreg_d = (byte_q == BYTE_W'(0)) ? 8'h0D : 8'h0A;
        byte_d  = byte_q + BYTE_W'(1);
        cnt_d   = '0;
        state_d = START;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered output values implied by the next state.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != IDLE);
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign tx_serial = tx_q;
  assign busy      = busy_q;
  assign tx_done   = done_q;

endmodule

// File: tb/tb_uart_result_tx.sv
// tb_uart_result_tx: self-checking bench for uart_result_tx (CLKS_PER_BIT=4).
// Each request is checked cycle by cycle against the ideal 8N1 waveform built
// from the frame list, and the captured line is also decoded by a UART receiver model.
module tb_uart_result_tx;

  localparam int CPB = 4;
`ifdef UART_RESULT_TX_CRLF_EN
  localparam int NFR = 3;
  localparam int FL  = 30 * CPB + 2;
`else
  localparam int NFR = 1;
  localparam int FL  = 10 * CPB;
`endif

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       send = 1'b0;
  logic [3:0] digit = 4'h0;
  logic       tx_serial;
  logic       busy;
  logic       tx_done;

  int errors = 0;
  int checks = 0;

  uart_result_tx #(
    .CLKS_PER_BIT(CPB),
    .CNT_W       (16)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .send     (send),
    .digit    (digit),
    .tx_serial(tx_serial),
    .busy     (busy),
    .tx_done  (tx_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] ascii(input int d);
    return (d < 10) ? 8'(8'h30 + d) : 8'h3F;
  endfunction

  // Idle cycles: line high, not busy, no done pulse.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk($sformatf("idle_tx %0d", i), 32'(tx_serial), 32'd1);
      chk($sformatf("idle_busy %0d", i), 32'(busy), 32'd0);
      chk($sformatf("idle_done %0d", i), 32'(tx_done), 32'd0);
    end
  endtask

  // One request: send d in the current cycle (cycle 0); optional extra send
  // pulses at cycles ia/ib (0 = none) must be ignored. Ends in cycle FL+1.
  task automatic transmit(input int d, input int ia, input int ib);
    logic [7:0] fr[$];
    logic       exp_line[$];
    logic       cap[$];
    logic [7:0] rx[$];
    int         i;

    fr.push_back(ascii(d));
`ifdef UART_RESULT_TX_CRLF_EN
    fr.push_back(8'h0D);
    fr.push_back(8'h0A);
`endif
    for (int f = 0; f < fr.size(); f++) begin
      if (f > 0) exp_line.push_back(1'b1);
      repeat (CPB) exp_line.push_back(1'b0);
      for (int b = 0; b < 8; b++) repeat (CPB) exp_line.push_back(fr[f][b]);
      repeat (CPB) exp_line.push_back(1'b1);
    end

    send  = 1'b1;
    digit = 4'(d);
    for (int c = 1; c <= FL + 1; c++) begin
      tick();
      cap.push_back(tx_serial);
      chk($sformatf("tx d=%0d c=%0d", d, c), 32'(tx_serial),
          32'((c <= FL) ? exp_line[c-1] : 1'b1));
      chk($sformatf("busy d=%0d c=%0d", d, c), 32'(busy), 32'(c <= FL));
      chk($sformatf("done d=%0d c=%0d", d, c), 32'(tx_done), 32'(c == FL));
      if (c <= FL && (c == ia || c == ib)) begin
        send  = 1'b1;
        digit = 4'd3;
      end else begin
        send  = 1'b0;
        digit = 4'($urandom_range(15));
      end
    end
    send = 1'b0;

    // Receiver model: find a start bit, sample mid-bit, require a high stop bit.
    i = 0;
    while (i < cap.size()) begin
      if (cap[i] == 1'b0 && i + CPB / 2 + 9 * CPB < cap.size()) begin
        logic [7:0] by;
        for (int b = 0; b < 8; b++) by[b] = cap[i + CPB / 2 + (b + 1) * CPB];
        chk($sformatf("rx_stop d=%0d", d), 32'(cap[i + CPB / 2 + 9 * CPB]), 32'd1);
        rx.push_back(by);
        i = i + CPB / 2 + 9 * CPB + 1;
      end else begin
        i++;
      end
    end
    chk($sformatf("rx_count d=%0d", d), 32'(rx.size()), 32'(NFR));
    for (int f = 0; f < NFR && f < rx.size(); f++) begin
      chk($sformatf("rx_byte d=%0d f=%0d", d, f), 32'(rx[f]), 32'(fr[f]));
    end
  endtask

  // Start a request, then assert reset asynchronously in cycle rc.
  task automatic reset_mid(input int d, input int rc);
    send  = 1'b1;
    digit = 4'(d);
    for (int c = 1; c <= rc; c++) begin
      tick();
      send = 1'b0;
    end
    #2 resetn = 1'b0;
    #1;
    chk($sformatf("rst_async_tx rc=%0d", rc), 32'(tx_serial), 32'd1);
    chk($sformatf("rst_async_busy rc=%0d", rc), 32'(busy), 32'd0);
    chk($sformatf("rst_async_done rc=%0d", rc), 32'(tx_done), 32'd0);
    tick();
    tick();
    chk($sformatf("rst_hold_tx rc=%0d", rc), 32'(tx_serial), 32'd1);
    #2 resetn = 1'b1;
    idle(3 * CPB);
  endtask

  initial begin
    // Reset state.
    tick();
    tick();
    chk("reset_tx", 32'(tx_serial), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(tx_done), 32'd0);
    #2 resetn = 1'b1;
    idle(3);

    // Single digit, then an invalid digit.
    transmit(7, 0, 0);
    idle(2);
    transmit(12, 0, 0);
    idle(1);

    // Sends during a frame are ignored; then back-to-back send right after tx_done.
    transmit(1, 5, 20);
    transmit(9, 0, 0);
    idle(2);

    // Reset during the start bit, then during DATA bit 4; then a clean '0'.
    reset_mid(6, 2);
    reset_mid(4, 1 + 5 * CPB + 1);
    transmit(0, 0, 0);
    idle(1);

    // Randomised requests with random ignored sends and gaps.
    for (int n = 0; n < 8; n++) begin
      int d;
      int gap;
      d   = int'($urandom_range(15));
      gap = int'($urandom_range(2));
      transmit(d, int'($urandom_range(FL, 1)), int'($urandom_range(FL, 1)));
      if (gap > 0) idle(gap);
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
